// File: rtl/alu_seq.sv
// Registered, handshaked ALU: single-cycle ADD/SUB/logic ops and a W-cycle shift-add multiply.
// Results and flags are held in an output register until the consumer takes them.
module alu_seq #(
    parameter int W  = 8,
    parameter int CW = $clog2(W) + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [W-1:0] data_a,
    input  logic [W-1:0] data_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         flag_z,
    output logic         flag_c,
    output logic         flag_v,
    output logic         flag_n
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        HOLD = 2'b10
    } state_t;

    state_t           state_r;
    logic [W-1:0]     a_r;
    logic [W-1:0]     b_r;
    logic [2*W-1:0]   acc_r;
    logic [CW-1:0]    cnt_r;
    logic [W-1:0]     result_r;
    logic             flag_z_r;
    logic             flag_c_r;
    logic             flag_v_r;
    logic             flag_n_r;
    logic             out_valid_r;

    logic [W:0]       sum_s;
    logic [W:0]       diff_s;
    logic [W-1:0]     alu_res_s;
    logic             alu_c_s;
    logic             alu_v_s;
    logic [W-1:0]     b_shift_s;
    logic [2*W-1:0]   addend_s;
    logic [2*W-1:0]   prod_s;

    assign in_ready  = (state_r == IDLE);
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign flag_z    = flag_z_r;
    assign flag_c    = flag_c_r;
    assign flag_v    = flag_v_r;
    assign flag_n    = flag_n_r;

    // Single-cycle datapath, evaluated on the live inputs at the accept edge
    always_comb begin
        sum_s     = {1'b0, data_a} + {1'b0, data_b};
        diff_s    = {1'b0, data_a} + {1'b0, ~data_b} + {{W{1'b0}}, 1'b1};
        alu_res_s = {W{1'b0}};
        alu_c_s   = 1'b0;
        alu_v_s   = 1'b0;
        case (op)
            3'b000: begin
                alu_res_s = sum_s[W-1:0];
                alu_c_s   = sum_s[W];
                alu_v_s   = (data_a[W-1] == data_b[W-1]) && (sum_s[W-1] != data_a[W-1]);
            end
            3'b001: begin
                alu_res_s = diff_s[W-1:0];
                alu_c_s   = diff_s[W];
                alu_v_s   = (data_a[W-1] != data_b[W-1]) && (diff_s[W-1] != data_a[W-1]);
            end
            3'b010:  alu_res_s = ~data_b;
            3'b011:  alu_res_s = {W{1'b0}};
            3'b100:  alu_res_s = data_a & data_b;
            3'b101:  alu_res_s = data_a | data_b;
            3'b110:  alu_res_s = data_a ^ data_b;
            default: alu_res_s = {W{1'b0}};
        endcase
    end

    // One shift-add multiply step: add A<<cnt when B bit [cnt] is set
    always_comb begin
        b_shift_s = b_r >> cnt_r;
        if (b_shift_s[0]) begin
            addend_s = {{W{1'b0}}, a_r} << cnt_r;
        end else begin
            addend_s = {(2*W){1'b0}};
        end
        prod_s = acc_r + addend_s;
    end

    // Control FSM with registered result, flags and out_valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            a_r         <= {W{1'b0}};
            b_r         <= {W{1'b0}};
            acc_r       <= {(2*W){1'b0}};
            cnt_r       <= {CW{1'b0}};
            result_r    <= {W{1'b0}};
            flag_z_r    <= 1'b0;
            flag_c_r    <= 1'b0;
            flag_v_r    <= 1'b0;
            flag_n_r    <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r <= data_a;
                        b_r <= data_b;
                        if (op == 3'b111) begin
                            acc_r   <= {(2*W){1'b0}};
                            cnt_r   <= {CW{1'b0}};
                            state_r <= MUL;
                        end else begin
                            result_r    <= alu_res_s;
                            flag_z_r    <= (alu_res_s == {W{1'b0}});
                            flag_c_r    <= alu_c_s;
                            flag_v_r    <= alu_v_s;
                            flag_n_r    <= alu_res_s[W-1];
                            out_valid_r <= 1'b1;
                            state_r     <= HOLD;
                        end
                    end
                end
                MUL: begin
                    acc_r <= prod_s;
                    if (cnt_r == CW'(W - 1)) begin
                        result_r    <= prod_s[W-1:0];
                        flag_z_r    <= (prod_s[W-1:0] == {W{1'b0}});
                        flag_c_r    <= |prod_s[2*W-1:W];
                        flag_v_r    <= 1'b0;
                        flag_n_r    <= prod_s[W-1];
                        out_valid_r <= 1'b1;
                        state_r     <= HOLD;
                    end else begin
                        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at W=4: table of ops with hand-computed results,
// plus hand-written sequences for reset, mid-multiply reset and backpressure.
module tb_alu_seq;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] data_a;
    logic [W-1:0] data_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         flag_z, flag_c, flag_v, flag_n;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [3:0]   zcvn;
        int           lat;
    } vec_t;

    vec_t vecs[13];

    alu_seq #(.W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .data_a    (data_a),
        .data_b    (data_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .flag_n    (flag_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int flags();
        return int'({flag_z, flag_c, flag_v, flag_n});
    endfunction

    // Called at a negedge; returns at the negedge where out_valid is seen (or budget expires).
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ordy, output int lat);
        op = o; data_a = a; data_b = b; out_ready = ordy; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        vecs[0]  = '{3'b000, 4'h7, 4'h1, 4'h8, 4'b0011, 1};
        vecs[1]  = '{3'b000, 4'hF, 4'h1, 4'h0, 4'b1100, 1};
        vecs[2]  = '{3'b001, 4'h3, 4'h5, 4'hE, 4'b0001, 1};
        vecs[3]  = '{3'b001, 4'h5, 4'h5, 4'h0, 4'b1100, 1};
        vecs[4]  = '{3'b001, 4'h8, 4'h1, 4'h7, 4'b0110, 1};
        vecs[5]  = '{3'b100, 4'hC, 4'hA, 4'h8, 4'b0001, 1};
        vecs[6]  = '{3'b101, 4'hC, 4'hA, 4'hE, 4'b0001, 1};
        vecs[7]  = '{3'b110, 4'hC, 4'hA, 4'h6, 4'b0000, 1};
        vecs[8]  = '{3'b010, 4'h0, 4'h3, 4'hC, 4'b0001, 1};
        vecs[9]  = '{3'b011, 4'h5, 4'h3, 4'h0, 4'b1000, 1};
        vecs[10] = '{3'b111, 4'h3, 4'h5, 4'hF, 4'b0001, 5};
        vecs[11] = '{3'b111, 4'hF, 4'hF, 4'h1, 4'b0100, 5};
        vecs[12] = '{3'b111, 4'h0, 4'h7, 4'h0, 4'b1000, 5};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = 3'b000; data_a = 4'h0; data_b = 4'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset in_ready", int'(in_ready), 1);
        check("reset out_valid", int'(out_valid), 0);
        check("reset result", int'(result), 0);
        check("reset flags", flags(), 0);

        // Table-driven ops, consumer always ready
        for (int i = 0; i < 13; i++) begin
            check($sformatf("v%0d in_ready", i), int'(in_ready), 1);
            issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, lat);
            check($sformatf("v%0d latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d result", i), int'(result), int'(vecs[i].res));
            check($sformatf("v%0d zcvn", i), flags(), int'(vecs[i].zcvn));
            @(negedge clk);
            check($sformatf("v%0d out_valid drop", i), int'(out_valid), 0);
        end

        // Backpressure: ADD 2+2 held for 6 cycles while extra requests are ignored
        issue(3'b000, 4'h2, 4'h2, 1'b0, lat);
        check("bp latency", lat, 1);
        op = 3'b000; data_a = 4'h9; data_b = 4'h9; in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("bp%0d out_valid", k), int'(out_valid), 1);
            check($sformatf("bp%0d result", k), int'(result), 4);
            check($sformatf("bp%0d in_ready", k), int'(in_ready), 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("bp release out_valid", int'(out_valid), 0);
        check("bp release result kept", int'(result), 4);
        check("bp release in_ready", int'(in_ready), 1);
        issue(3'b000, 4'h1, 4'h1, 1'b1, lat);
        check("bp next latency", lat, 1);
        check("bp next result", int'(result), 2);
        @(negedge clk);

        // Reset during HOLD drops out_valid without waiting for a clock edge
        issue(3'b101, 4'h5, 4'h2, 1'b0, lat);
        check("hold before reset", int'(out_valid), 1);
        #2 reset = 1'b1;
        #1;
        check("hold async out_valid", int'(out_valid), 0);
        check("hold async result", int'(result), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("hold post reset in_ready", int'(in_ready), 1);

        // Reset mid-multiply discards the operation
        out_ready = 1'b1;
        op = 3'b111; data_a = 4'h3; data_b = 4'h5; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("mul busy in_ready", int'(in_ready), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mul reset in_ready", int'(in_ready), 1);
        lat = 0;
        for (int k = 0; k < W + 3; k++) begin
            @(negedge clk);
            if (out_valid) lat++;
        end
        check("mul reset no out_valid", lat, 0);
        check("mul reset result", int'(result), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
